// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential reads to a single-cycle-latency RAM
// and buffers the returned words with their addresses in a small FIFO that the
// decoder drains. A redirect flushes the buffer, drops any read still in flight,
// and restarts fetching at the new address.
module instr_fetch #(
    parameter logic [11:0] RESET_PC = 12'h000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] mem_addr,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    output logic [15:0] instr,
    output logic [11:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    // DEPTH is limited to 2..4, so two pointer bits and three count bits suffice.
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = (DEPTH > 3) ? 3 : 2;

    logic [11:0]   fetch_pc;
    logic [15:0]   fifo_data [DEPTH];
    logic [11:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          inflight;
    logic [11:0]   inflight_pc;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occupancy;
    logic [CW:0]   limit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_data[head] : 16'h0000;
    assign instr_pc    = instr_valid ? fifo_pc[head]   : 12'h000;
    assign mem_addr    = fetch_pc;
    assign mem_re      = issue;

    // Issue only when a buffer slot is guaranteed for the response; the in-flight
    // read already owns one slot, and a pop this cycle frees one.
    always_comb begin
        pop       = instr_valid && instr_ready && !redirect;
        push      = inflight && !redirect;
        occupancy = {1'b0, count} + (CW + 1)'(inflight);
        limit     = (CW + 1)'(DEPTH) + (CW + 1)'(pop);
        issue     = !rst && !redirect && (occupancy < limit);
    end

    // Fetch pointer, in-flight tracking and FIFO bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            inflight    <= 1'b0;
            inflight_pc <= 12'h000;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 12'd1;
            end
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[tail] <= mem_rdata;
            fifo_pc[tail]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] mem_addr;
    logic        mem_re;
    logic [15:0] mem_rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = 12'h000;
    logic [15:0] instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b1;

    logic [11:0] mem_addr2;
    logic        mem_re2;
    logic [15:0] mem_rdata2 = 16'h0000;
    logic        redirect2 = 1'b0;
    logic [11:0] redirect_pc2 = 12'h000;
    logic [15:0] instr2;
    logic [11:0] instr_pc2;
    logic        instr_valid2;
    logic        instr_ready2 = 1'b1;

    logic [15:0] ram [4096];

    int errors = 0;
    int checks = 0;

    logic        sb_en = 1'b0;
    logic [11:0] q_pc[$];
    logic [15:0] q_data[$];
    logic [11:0] next_push_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(12'h000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready)
    );

    instr_fetch #(.RESET_PC(12'hFFE), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst(rst), .mem_addr(mem_addr2), .mem_re(mem_re2),
        .mem_rdata(mem_rdata2), .redirect(redirect2), .redirect_pc(redirect_pc2),
        .instr(instr2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
        .instr_ready(instr_ready2)
    );

    // Synchronous RAM: address sampled at the edge, data valid the next cycle.
    always @(posedge clk) begin
        if (mem_re)  mem_rdata  <= ram[mem_addr];
        if (mem_re2) mem_rdata2 <= ram[mem_addr2];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Expected stream: consecutive RAM words starting at the last reset/redirect target.
    task automatic topup();
        while (q_pc.size() < 16) begin
            q_pc.push_back(next_push_pc);
            q_data.push_back(ram[next_push_pc]);
            next_push_pc = next_push_pc + 12'd1;
        end
    endtask

    // Scoreboard monitor: compares every delivered instruction against the queue.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            check("count_le_depth", (int'(dut.count) <= DEPTH) ? 32'd1 : 32'd0, 32'd1);
            if (!instr_valid) begin
                check("idle_instr_zero", {instr, 4'h0, instr_pc}, 32'd0);
            end else if (instr_ready && !redirect) begin
                if (q_pc.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL sb_underflow: got pc %h with no expected entry", instr_pc);
                end else begin
                    check("sb_pc", instr_pc, q_pc.pop_front());
                    check("sb_data", instr, q_data.pop_front());
                end
            end
        end
    end

    initial begin
        int re_cnt;
        int waited;
        logic found;

        for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
        ram[12'h000] = 16'hA5A5;
        ram[12'h001] = 16'h5A5A;
        ram[12'h002] = 16'hFFFF;
        ram[12'h003] = 16'h1234;
        ram[12'h100] = 16'hBEEF;
        ram[12'hFFE] = 16'h0FFE;
        ram[12'hFFF] = 16'h0FFF;

        // Reset state.
        #2;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_mem_re", mem_re, 1'b0);
        check("rst_instr", {instr, 4'h0, instr_pc}, 32'd0);

        // Sequential fill, plus address/pc wrap on the second instance.
        instr_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k < 3) begin
                check("fill_addr", mem_addr, 32'(k));
                check("fill_re", mem_re, 1'b1);
            end
            if (k < 2) begin
                check("fill_latency", instr_valid, 1'b0);
            end else begin
                check("fill_valid", instr_valid, 1'b1);
                check("fill_pc", instr_pc, 32'(k - 2));
                check("fill_data", instr, ram[12'(k - 2)]);
            end
            if (k < 4) check("wrap_addr", mem_addr2, 32'(12'(12'hFFE + 12'(k))));
            if (k >= 2) check("wrap_pc", instr_pc2, 32'(12'(12'hFFE + 12'(k - 2))));
        end

        // Stalled decoder: exactly DEPTH reads, head held, then resume gap-free.
        instr_ready = 1'b0;
        do_reset();
        re_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_re) re_cnt++;
        end
        check("stall_reads", re_cnt, DEPTH);
        check("stall_re_low", mem_re, 1'b0);
        check("stall_valid", instr_valid, 1'b1);
        check("stall_head", {instr, 4'h0, instr_pc}, {16'hA5A5, 16'h0000});
        @(posedge clk);
        #1 instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("resume_valid", instr_valid, 1'b1);
            check("resume_pc", instr_pc, 32'(k));
            check("resume_data", instr, ram[12'(k)]);
        end

        // Redirect while the read of 003 is in flight.
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (mem_re && mem_addr == 12'h003) found = 1'b1;
        end
        check("redir_seen_003", found, 1'b1);
        @(posedge clk);
        #1 redirect = 1'b1;
        redirect_pc = 12'h100;
        @(negedge clk);
        check("redir_re_low", mem_re, 1'b0);
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        check("redir_flushed", instr_valid, 1'b0);
        check("redir_addr", {mem_re, 3'b0, mem_addr}, {1'b1, 3'b0, 12'h100});
        @(negedge clk);
        check("redir_latency", instr_valid, 1'b0);
        @(negedge clk);
        check("redir_first", {instr_valid, 3'b0, instr_pc}, {1'b1, 3'b0, 12'h100});
        check("redir_data", instr, 16'hBEEF);
        @(negedge clk);
        check("redir_next", instr_pc, 12'h101);
        check("redir_active", {instr_valid, mem_re}, 2'b11);

        // Asynchronous reset between edges while busy.
        #2 rst = 1'b1;
        #1;
        check("async_valid", instr_valid, 1'b0);
        check("async_re", mem_re, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        found = 1'b0;
        waited = 0;
        while (!found && waited < 10) begin
            @(negedge clk);
            waited++;
            if (instr_valid) found = 1'b1;
        end
        check("post_rst_seen", found, 1'b1);
        check("post_rst_pc", instr_pc, 12'h000);
        check("post_rst_data", instr, ram[12'h000]);

        // Random ready/redirect traffic against the scoreboard.
        do_reset();
        q_pc.delete();
        q_data.delete();
        next_push_pc = 12'h000;
        topup();
        sb_en = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 24) == 0);
            if (redirect) begin
                redirect_pc = 12'($urandom_range(0, 4095));
                q_pc.delete();
                q_data.delete();
                next_push_pc = redirect_pc;
            end
            topup();
        end
        @(posedge clk);
        #1 redirect = 1'b0;
        @(negedge clk);
        sb_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
